// File: rtl/ddr2_spd_i2c_responder.sv
// I2C target that serves a DDR2 SPD-style byte store, with a local preload write port.
// Bus inputs are synchronized and every protocol decision is taken on synced SCL edges.
module ddr2_spd_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       mem_wr,
  input  logic [7:0] mem_addr,
  input  logic [7:0] mem_wdata,
  output logic       busy,
  output logic       addressed
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  typedef enum logic [3:0] {
    StIdle, StDevAddr, StAckDev, StWordAddr, StAckWord,
    StWrData, StAckWr, StRdData, StRdAck
  } state_e;

  state_e          state_q;
  logic [3:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic [AW-1:0]   ptr_q;
  logic            rw_q, nack_q, commit_q;
  logic [7:0]      mem [MEM_DEPTH];

  logic scl_meta, scl_sync, scl_dly, sda_meta, sda_sync, sda_dly;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte, rd_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      {scl_meta, scl_sync, scl_dly} <= 3'b111;
      {sda_meta, sda_sync, sda_dly} <= 3'b111;
    end else begin
      {scl_meta, scl_sync, scl_dly} <= {scl_in, scl_meta, scl_sync};
      {sda_meta, sda_sync, sda_dly} <= {sda_in, sda_meta, sda_sync};
    end
  end

  assign scl_rise  = scl_sync & ~scl_dly;
  assign scl_fall  = ~scl_sync & scl_dly;
  assign start_det = scl_sync & scl_dly & sda_dly & ~sda_sync;
  assign stop_det  = scl_sync & scl_dly & ~sda_dly & sda_sync;
  assign rx_byte   = {shift_q[6:0], sda_sync};
  assign rd_byte   = mem[ptr_q];

  // I2C commit owns the array in its cycle; a colliding local write is dropped.
  always_ff @(posedge clk) begin
    if (commit_q) begin
      mem[ptr_q] <= shift_q;
    end else if (mem_wr) begin
      mem[mem_addr[AW-1:0]] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      addressed <= 1'b0;
      ptr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      nack_q    <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (commit_q) ptr_q <= ptr_q + AW'(1);
      if (stop_det) begin
        state_q   <= StIdle;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        addressed <= 1'b0;
        bit_cnt_q <= '0;
      end else if (start_det) begin
        state_q   <= StDevAddr;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
        addressed <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StDevAddr, StWordAddr, StWrData: begin
            if (scl_rise) begin
              shift_q   <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= '0;
                if (state_q == StDevAddr) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_q   <= StAckDev;
                    addressed <= 1'b1;
                    rw_q      <= rx_byte[0];
                  end else begin
                    state_q <= StIdle;
                  end
                end else if (state_q == StWordAddr) begin
                  ptr_q   <= rx_byte[AW-1:0];
                  state_q <= StAckWord;
                end else begin
                  commit_q <= 1'b1;
                  state_q  <= StAckWr;
                end
              end
            end
          end
          // First fall after the 8th bit starts the ACK; the next fall ends it.
          StAckDev, StAckWord, StAckWr: begin
            if (scl_fall) begin
              if (bit_cnt_q == 4'd0) begin
                sda_oe    <= 1'b1;
                bit_cnt_q <= 4'd1;
              end else begin
                bit_cnt_q <= '0;
                if (state_q == StAckDev && rw_q) begin
                  state_q <= StRdData;
                  shift_q <= rd_byte;
                  sda_oe  <= ~rd_byte[7];
                end else begin
                  sda_oe  <= 1'b0;
                  state_q <= (state_q == StAckDev) ? StWordAddr : StWrData;
                end
              end
            end
          end
          StRdData: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe    <= 1'b0;
                ptr_q     <= ptr_q + AW'(1);
                bit_cnt_q <= '0;
                state_q   <= StRdAck;
              end else begin
                shift_q <= {shift_q[6:0], 1'b0};
                sda_oe  <= ~shift_q[6];
              end
            end
          end
          StRdAck: begin
            if (scl_rise) begin
              nack_q    <= sda_sync;
              bit_cnt_q <= 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd1) begin
              bit_cnt_q <= '0;
              if (!nack_q) begin
                state_q <= StRdData;
                shift_q <= rd_byte;
                sda_oe  <= ~rd_byte[7];
              end else begin
                state_q <= StIdle;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ddr2_spd_i2c_responder.sv
// Bit-banged I2C master with a byte-array reference model of the SPD store and pointer.
module tb_ddr2_spd_i2c_responder;
  logic       clk = 1'b0;
  logic       reset, scl_in, sda_m, mem_wr;
  logic [7:0] mem_addr, mem_wdata;
  logic       sda_oe, busy, addressed, sda_line;

  always #5 clk = ~clk;
  assign sda_line = sda_m & ~sda_oe;

  ddr2_spd_i2c_responder dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .addressed (addressed)
  );

  int errors = 0, checks = 0;
  logic [7:0] ref_mem [256];
  int ref_ptr = 0;
  logic [7:0] wbuf [4];

  // SDA must only move while SCL is low (reset excepted).
  int   oe_glitch = 0, oe_cycles = 0;
  logic oe_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!reset && scl_in && sda_oe !== oe_prev) oe_glitch <= oe_glitch + 1;
    if (sda_oe === 1'b1) oe_cycles <= oe_cycles + 1;
    oe_prev <= sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic quarter();
    repeat (4) @(negedge clk);
  endtask

  task automatic bit_cycle(input logic b, input bit collide, output logic line);
    sda_m = b;
    half();
    scl_in = 1'b1;
    if (collide) begin
      // Local write lands on the same clock as the I2C commit of this byte.
      repeat (3) @(posedge clk);
      @(negedge clk);
      mem_wr = 1'b1; mem_addr = 8'h05; mem_wdata = 8'hA5;
      @(negedge clk);
      mem_wr = 1'b0;
      repeat (6) @(negedge clk);
    end else begin
      half();
    end
    line = sda_line;
    scl_in = 1'b0;
    quarter();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; quarter();
    scl_in = 1'b1; half();
    sda_m = 1'b0; half();
    scl_in = 1'b0; quarter();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; quarter();
    scl_in = 1'b1; half();
    sda_m = 1'b1; half();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit collide, output bit acked);
    logic l;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], collide && (i == 0), l);
    bit_cycle(1'b1, 1'b0, l);
    acked = (l == 1'b0);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic l;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, 1'b0, l);
      d[i] = l;
    end
    bit_cycle(nack, 1'b0, l);
  endtask

  task automatic i2c_write(input logic [7:0] addr, input int n);
    bit a;
    i2c_start();
    check("wr_busy", busy, 1'b1);
    send_byte(8'hA0, 1'b0, a); check("wr_dev_ack", a, 1'b1);
    check("wr_addressed", addressed, 1'b1);
    send_byte(addr, 1'b0, a); check("wr_word_ack", a, 1'b1);
    for (int k = 0; k < n; k++) begin
      send_byte(wbuf[k], 1'b0, a); check($sformatf("wr_data_ack%0d", k), a, 1'b1);
      ref_mem[(addr + k) % 256] = wbuf[k];
    end
    ref_ptr = (addr + n) % 256;
    i2c_stop();
    check("wr_idle_busy", busy, 1'b0);
  endtask

  task automatic i2c_read(input bit set_addr, input logic [7:0] addr, input int n);
    bit a;
    logic [7:0] d;
    i2c_start();
    if (set_addr) begin
      send_byte(8'hA0, 1'b0, a); check("rd_dev_wr_ack", a, 1'b1);
      send_byte(addr, 1'b0, a); check("rd_word_ack", a, 1'b1);
      ref_ptr = addr;
      i2c_start();
    end
    send_byte(8'hA1, 1'b0, a); check("rd_dev_ack", a, 1'b1);
    check("rd_addressed", addressed, 1'b1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, d);
      check($sformatf("rd_byte%0d@%0h", k, ref_ptr), d, ref_mem[ref_ptr]);
      ref_ptr = (ref_ptr + 1) % 256;
    end
    i2c_stop();
    check("rd_idle_busy", busy, 1'b0);
    check("rd_idle_addr", addressed, 1'b0);
  endtask

  initial begin
    bit a;
    logic l;
    int oe_base, n;
    logic [7:0] addr;

    reset = 1'b1; scl_in = 1'b1; sda_m = 1'b1;
    mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addressed", addressed, 1'b0);

    // Random preload of the whole store, then the SPD header bytes.
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      if (i < 4) ref_mem[i] = (i == 0) ? 8'h80 : (i == 3) ? 8'h0E : 8'h08;
      mem_wr = 1'b1; mem_addr = 8'(i); mem_wdata = ref_mem[i];
      @(negedge clk);
    end
    mem_wr = 1'b0;

    // Header read via word-address write then repeated START.
    i2c_read(1'b1, 8'h00, 4);

    // Wrong device address: never acknowledged, busy until STOP.
    oe_base = oe_cycles;
    i2c_start();
    send_byte(8'hA2, 1'b0, a); check("nomatch_ack", a, 1'b0);
    check("nomatch_addressed", addressed, 1'b0);
    check("nomatch_busy", busy, 1'b1);
    send_byte(8'h00, 1'b0, a);
    i2c_stop();
    check("nomatch_busy_stop", busy, 1'b0);
    check("nomatch_oe_cycles", oe_cycles - oe_base, 0);

    // Pointer wrap on write, then random reads of both bytes.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    i2c_write(8'hFF, 2);
    i2c_read(1'b1, 8'hFF, 1);
    i2c_read(1'b1, 8'h00, 1);

    // STOP after 4 data bits: nothing written, bus released.
    i2c_start();
    send_byte(8'hA0, 1'b0, a);
    send_byte(8'h10, 1'b0, a);
    ref_ptr = 8'h10;
    addr = ~ref_mem[8'h10];
    for (int i = 7; i >= 4; i--) bit_cycle(addr[i], 1'b0, l);
    i2c_stop();
    check("abort_oe", sda_oe, 1'b0);
    check("abort_busy", busy, 1'b0);
    i2c_read(1'b0, 8'h00, 1);

    // Local write collides with the I2C commit: the I2C byte wins.
    i2c_start();
    send_byte(8'hA0, 1'b0, a);
    send_byte(8'h05, 1'b0, a);
    send_byte(8'h5A, 1'b1, a); check("coll_ack", a, 1'b1);
    i2c_stop();
    ref_mem[5] = 8'h5A;
    ref_ptr = 6;
    i2c_read(1'b1, 8'h05, 1);

    // Reset while the DUT holds SDA low on a read bit.
    i2c_start();
    send_byte(8'hA0, 1'b0, a);
    send_byte(8'h02, 1'b0, a);
    i2c_start();
    send_byte(8'hA1, 1'b0, a);
    sda_m = 1'b1; half();
    scl_in = 1'b1; half();
    check("rstmid_drive", sda_oe, ref_mem[2][7] == 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_release", sda_oe, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    scl_in = 1'b0; quarter();
    oe_base = oe_cycles;
    for (int i = 0; i < 9; i++) bit_cycle(1'b1, 1'b0, l);
    i2c_stop();
    check("rstmid_ignored", oe_cycles - oe_base, 0);
    ref_ptr = 0;
    i2c_read(1'b0, 8'h00, 4);

    // Randomized mix of writes, addressed reads and current-address reads.
    for (int t = 0; t < 10; t++) begin
      addr = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      n = $urandom_range(1, 4);
      case ($urandom_range(0, 2))
        0: begin
          for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
          i2c_write(addr, n);
        end
        1: i2c_read(1'b1, addr, n);
        default: i2c_read(1'b0, 8'h00, n);
      endcase
    end

    check("oe_only_scl_low", oe_glitch, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
